// File: rtl/ddr2_24x64_8_phy_alt_mem_phy_pll_phs_shft_ctrl_pkg.sv
// Shared encodings for the PLL phase-shift controller.
// Holds the FSM states, the timeout counter width and the PLL direction encoding.
package ddr2_24x64_8_phy_alt_mem_phy_pll_phs_shft_ctrl_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_SETUP     = 3'd1;
  localparam logic [STATE_W-1:0] ST_STEP      = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT_LOW  = 3'd3;
  localparam logic [STATE_W-1:0] ST_WAIT_HIGH = 3'd4;
  localparam logic [STATE_W-1:0] ST_UPDATE    = 3'd5;

  localparam int TMO_CNT_W  = 8;
  localparam int HOLD_CNT_W = 3;

  localparam logic PLL_DIR_UP = 1'b1;

endpackage

// File: rtl/ddr2_24x64_8_phy_alt_mem_phy_sync_2ff.sv
// One-bit two-flop synchronizer for asynchronous PHY inputs.
// RESET_VAL sets the idle level both flops take on reset.
module ddr2_24x64_8_phy_alt_mem_phy_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= RESET_VAL;
      sync_p1 <= RESET_VAL;
    end else begin
      meta_p0 <= async_in;
      sync_p1 <= meta_p0;
    end
  end

  assign sync_out = sync_p1;

endmodule

// File: rtl/ddr2_24x64_8_phy_alt_mem_phy_pll_phs_shft_ctrl.sv
// Turns sequencer phase-step requests into the ALTPLL dynamic phase-shift handshake
// and tracks each output counter's phase position modulo PLL_STEPS_PER_CYCLE.
module ddr2_24x64_8_phy_alt_mem_phy_pll_phs_shft_ctrl
  import ddr2_24x64_8_phy_alt_mem_phy_pll_phs_shft_ctrl_pkg::*;
#(
  parameter int CLOCK_INDEX_WIDTH   = 4,
  parameter int NUM_CLOCKS          = 10,
  parameter int PLL_STEPS_PER_CYCLE = 32,
  parameter int PHASE_WIDTH         = 5,
  parameter int STEP_HOLD_CYCLES    = 2,
  parameter int DONE_TIMEOUT        = 255
) (
  input  logic                         seq_clk,
  input  logic                         reset_seq,
  input  logic                         seq_pll_start_reconfig,
  input  logic [CLOCK_INDEX_WIDTH-1:0] seq_pll_select,
  input  logic                         seq_pll_inc_dec_n,
  output logic                         phs_shft_busy,
  output logic [CLOCK_INDEX_WIDTH-1:0] pll_phasecounterselect,
  output logic                         pll_phaseupdown,
  output logic                         pll_phasestep,
  input  logic                         pll_phasedone,
  input  logic [CLOCK_INDEX_WIDTH-1:0] phase_rd_index,
  output logic [PHASE_WIDTH-1:0]       phase_rd_value,
  output logic                         shift_err_bad_index,
  output logic                         shift_err_timeout,
  output logic                         shift_err_overrun
);

  localparam logic [CLOCK_INDEX_WIDTH:0] NUM_CLOCKS_W = (CLOCK_INDEX_WIDTH+1)'(NUM_CLOCKS);
  localparam logic [PHASE_WIDTH-1:0]     PHASE_MAX    = PHASE_WIDTH'(PLL_STEPS_PER_CYCLE - 1);
  localparam logic [HOLD_CNT_W-1:0]      HOLD_LAST    = HOLD_CNT_W'(STEP_HOLD_CYCLES - 1);
  localparam logic [TMO_CNT_W-1:0]       TMO_LAST     = TMO_CNT_W'(DONE_TIMEOUT - 1);

  logic [STATE_W-1:0]     state_q;
  logic [HOLD_CNT_W-1:0]  hold_cnt_q;
  logic [TMO_CNT_W-1:0]   tmo_cnt_q;
  logic [PHASE_WIDTH-1:0] phase_q [NUM_CLOCKS];
  logic                   done_s;
  logic                   sel_in_range;
  logic                   rd_in_range;

  function automatic logic [PHASE_WIDTH-1:0] next_phase(input logic [PHASE_WIDTH-1:0] cur,
                                                        input logic up);
    if (up == PLL_DIR_UP)
      return (cur == PHASE_MAX) ? '0 : cur + PHASE_WIDTH'(1);
    else
      return (cur == '0) ? PHASE_MAX : cur - PHASE_WIDTH'(1);
  endfunction

  // phasedone idles high, so the synchronizer resets high to avoid a false handshake edge
  ddr2_24x64_8_phy_alt_mem_phy_sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_done_sync (
    .clk      (seq_clk),
    .rst      (reset_seq),
    .async_in (pll_phasedone),
    .sync_out (done_s)
  );

  assign sel_in_range = {1'b0, seq_pll_select} < NUM_CLOCKS_W;
  assign rd_in_range  = {1'b0, phase_rd_index} < NUM_CLOCKS_W;

  always_ff @(posedge seq_clk) begin
    if (reset_seq) begin
      state_q                <= ST_IDLE;
      hold_cnt_q             <= '0;
      tmo_cnt_q              <= '0;
      phs_shft_busy          <= 1'b0;
      pll_phasestep          <= 1'b0;
      pll_phaseupdown        <= 1'b0;
      pll_phasecounterselect <= '0;
      phase_rd_value         <= '0;
      shift_err_bad_index    <= 1'b0;
      shift_err_timeout      <= 1'b0;
      shift_err_overrun      <= 1'b0;
      for (int i = 0; i < NUM_CLOCKS; i++) phase_q[i] <= '0;
    end else begin
      phase_rd_value <= rd_in_range ? phase_q[phase_rd_index] : '0;

      if (seq_pll_start_reconfig && (state_q != ST_IDLE))
        shift_err_overrun <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (seq_pll_start_reconfig) begin
            if (sel_in_range) begin
              pll_phasecounterselect <= seq_pll_select;
              pll_phaseupdown        <= seq_pll_inc_dec_n;
              phs_shft_busy          <= 1'b1;
              state_q                <= ST_SETUP;
            end else begin
              shift_err_bad_index <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          hold_cnt_q    <= '0;
          pll_phasestep <= 1'b1;
          state_q       <= ST_STEP;
        end
        ST_STEP: begin
          if (hold_cnt_q == HOLD_LAST) begin
            pll_phasestep <= 1'b0;
            tmo_cnt_q     <= '0;
            state_q       <= ST_WAIT_LOW;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_CNT_W'(1);
          end
        end
        ST_WAIT_LOW, ST_WAIT_HIGH: begin
          tmo_cnt_q <= tmo_cnt_q + TMO_CNT_W'(1);
          if ((state_q == ST_WAIT_LOW) && !done_s) begin
            state_q <= ST_WAIT_HIGH;
          end else if ((state_q == ST_WAIT_HIGH) && done_s) begin
            state_q <= ST_UPDATE;
          end else if (tmo_cnt_q == TMO_LAST) begin
            shift_err_timeout <= 1'b1;
            phs_shft_busy     <= 1'b0;
            state_q           <= ST_IDLE;
          end
        end
        ST_UPDATE: begin
          phase_q[pll_phasecounterselect] <= next_phase(phase_q[pll_phasecounterselect],
                                                        pll_phaseupdown);
          phs_shft_busy <= 1'b0;
          state_q       <= ST_IDLE;
        end
        default: begin
          pll_phasestep <= 1'b0;
          phs_shft_busy <= 1'b0;
          state_q       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr2_24x64_8_phy_alt_mem_phy_pll_phs_shft_ctrl.sv
// Bench for the PLL phase-shift controller: directed handshake sequences, a vector
// table and randomized requests checked against a modular-arithmetic phase model.
module tb_ddr2_24x64_8_phy_alt_mem_phy_pll_phs_shft_ctrl;

  localparam int NCLK  = 10;
  localparam int STEPS = 32;
  localparam int HOLD  = 2;
  localparam int TMO   = 255;

  logic       clk = 1'b0;
  logic       reset_seq;
  logic       start;
  logic [3:0] sel;
  logic       inc;
  logic       busy;
  logic [3:0] pcs;
  logic       pud;
  logic       pstep;
  logic       pdone_m;
  logic       force_low;
  logic       pdone;
  logic [3:0] rd_idx;
  logic [4:0] rd_val;
  logic       e_bad, e_tmo, e_ovr;

  int checks = 0;
  int errors = 0;
  int low_dly = 3;
  int high_dly = 4;
  int pulse_cnt = 0;
  int ref_phase [NCLK];

  typedef struct {
    int idx;
    bit up;
    bit accept;
    int exp_phase;
  } vec_t;
  vec_t vecs [11];

  always #5 clk = ~clk;

  assign pdone = pdone_m & ~force_low;

  ddr2_24x64_8_phy_alt_mem_phy_pll_phs_shft_ctrl dut (
    .seq_clk                (clk),
    .reset_seq              (reset_seq),
    .seq_pll_start_reconfig (start),
    .seq_pll_select         (sel),
    .seq_pll_inc_dec_n      (inc),
    .phs_shft_busy          (busy),
    .pll_phasecounterselect (pcs),
    .pll_phaseupdown        (pud),
    .pll_phasestep          (pstep),
    .pll_phasedone          (pdone),
    .phase_rd_index         (rd_idx),
    .phase_rd_value         (rd_val),
    .shift_err_bad_index    (e_bad),
    .shift_err_timeout      (e_tmo),
    .shift_err_overrun      (e_ovr)
  );

  // PLL model: phasedone drops low_dly cycles after phasestep rises, returns high_dly later
  initial pdone_m = 1'b1;
  always begin
    @(posedge pstep);
    repeat (low_dly) @(posedge clk);
    #1 pdone_m = 1'b0;
    repeat (high_dly) @(posedge clk);
    #1 pdone_m = 1'b1;
  end

  always @(posedge pstep) pulse_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("wait_idle", busy, 0);
  endtask

  task automatic read_phase(input int idx, output int val);
    rd_idx = 4'(idx);
    tick();
    val = rd_val;
  endtask

  task automatic model_shift(input int idx, input bit up);
    if (idx < NCLK) ref_phase[idx] = (ref_phase[idx] + (up ? 1 : STEPS - 1)) % STEPS;
  endtask

  task automatic do_shift(input int idx, input bit up, input int ld, input int hd);
    low_dly = ld;
    high_dly = hd;
    start = 1'b1;
    sel = 4'(idx);
    inc = up;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, (idx < NCLK) ? 1 : 0);
    wait_idle(400);
    model_shift(idx, up);
  endtask

  task automatic check_all_phases(input string name);
    int v;
    for (int i = 0; i < NCLK; i++) begin
      read_phase(i, v);
      check(name, v, ref_phase[i]);
    end
  endtask

  initial begin
    int v, p0, n;
    reset_seq = 1'b1;
    start = 1'b0;
    sel = '0;
    inc = 1'b0;
    rd_idx = '0;
    force_low = 1'b0;
    for (int i = 0; i < NCLK; i++) ref_phase[i] = 0;

    vecs[0]  = '{5, 1'b1, 1'b1, 1};
    vecs[1]  = '{5, 1'b1, 1'b1, 2};
    vecs[2]  = '{5, 1'b0, 1'b1, 1};
    vecs[3]  = '{6, 1'b0, 1'b1, 31};
    vecs[4]  = '{6, 1'b0, 1'b1, 30};
    vecs[5]  = '{6, 1'b1, 1'b1, 31};
    vecs[6]  = '{7, 1'b1, 1'b1, 1};
    vecs[7]  = '{9, 1'b0, 1'b1, 31};
    vecs[8]  = '{9, 1'b1, 1'b1, 0};
    vecs[9]  = '{10, 1'b1, 1'b0, 0};
    vecs[10] = '{15, 1'b0, 1'b0, 0};

    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_phasestep", pstep, 0);
    check("rst_updown", pud, 0);
    check("rst_select", pcs, 0);
    check("rst_rd_value", rd_val, 0);
    check("rst_err_bad", e_bad, 0);
    check("rst_err_tmo", e_tmo, 0);
    check("rst_err_ovr", e_ovr, 0);
    reset_seq = 1'b0;
    tick();
    check_all_phases("rst_phase");

    // Increment on index 3 with cycle-accurate handshake checks
    low_dly = 3;
    high_dly = 4;
    start = 1'b1;
    sel = 4'd3;
    inc = 1'b1;
    tick();
    start = 1'b0;
    check("inc3_busy_T1", busy, 1);
    check("inc3_sel_T1", pcs, 3);
    check("inc3_ud_T1", pud, 1);
    check("inc3_step_T1", pstep, 0);
    tick();
    check("inc3_step_T2", pstep, 1);
    check("inc3_sel_T2", pcs, 3);
    tick();
    check("inc3_step_T3", pstep, 1);
    check("inc3_ud_T3", pud, 1);
    tick();
    check("inc3_step_T4", pstep, 0);
    wait_idle(100);
    model_shift(3, 1'b1);
    read_phase(3, v);
    check("inc3_phase", v, 1);

    // Wrap-around on index 0
    for (int k = 0; k < STEPS; k++) do_shift(0, 1'b1, 2, 2);
    read_phase(0, v);
    check("wrap_up_phase0", v, 0);
    do_shift(0, 1'b0, 1, 3);
    read_phase(0, v);
    check("wrap_dn_phase0", v, 31);

    // Out-of-range select
    check("bad_flag_before", e_bad, 0);
    n = pulse_cnt;
    start = 1'b1;
    sel = 4'd12;
    inc = 1'b1;
    tick();
    start = 1'b0;
    check("bad_flag", e_bad, 1);
    v = 0;
    for (int k = 0; k < 8; k++) begin
      if (busy) v = 1;
      tick();
    end
    check("bad_busy_seen", v, 0);
    check("bad_no_step", pulse_cnt - n, 0);

    // Vector table
    for (int t = 0; t < 11; t++) begin
      do_shift(vecs[t].idx, vecs[t].up, 2, 3);
      if (vecs[t].accept) begin
        read_phase(vecs[t].idx, v);
        check("vec_phase", v, vecs[t].exp_phase);
      end else begin
        check("vec_bad_flag", e_bad, 1);
      end
    end

    // Overrun: second start while busy is ignored
    check("ovr_flag_before", e_ovr, 0);
    read_phase(8, p0);
    n = pulse_cnt;
    low_dly = 3;
    high_dly = 4;
    start = 1'b1;
    sel = 4'd8;
    inc = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    sel = 4'd4;
    inc = 1'b0;
    tick();
    start = 1'b0;
    check("ovr_flag", e_ovr, 1);
    wait_idle(100);
    model_shift(8, 1'b1);
    check("ovr_pulses", pulse_cnt - n, 1);
    read_phase(8, v);
    check("ovr_phase8", v, (p0 + 1) % STEPS);
    read_phase(4, v);
    check("ovr_phase4", v, ref_phase[4]);

    // Timeout: phasedone never returns high
    read_phase(1, p0);
    force_low = 1'b1;
    start = 1'b1;
    sel = 4'd1;
    inc = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 400) begin
      n++;
      tick();
    end
    check("tmo_busy_cycles", n, 1 + HOLD + TMO);
    check("tmo_flag", e_tmo, 1);
    check("tmo_busy", busy, 0);
    read_phase(1, v);
    check("tmo_phase1", v, p0);
    force_low = 1'b0;
    repeat (10) tick();

    // Randomized requests against the reference model
    for (int k = 0; k < 40; k++) begin
      int idx;
      bit up;
      idx = int'($urandom_range(0, 11));
      up = 1'($urandom_range(0, 1));
      do_shift(idx, up, int'($urandom_range(1, 5)), int'($urandom_range(1, 6)));
      if (idx < NCLK) begin
        read_phase(idx, v);
        check("rand_phase", v, ref_phase[idx]);
      end
    end
    check_all_phases("rand_final");

    // Reset during WAIT_HIGH
    low_dly = 2;
    high_dly = 30;
    start = 1'b1;
    sel = 4'd2;
    inc = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (pdone_m && n < 50) begin
      tick();
      n++;
    end
    check("rstmid_done_low", pdone_m, 0);
    repeat (4) tick();
    check("rstmid_busy_before", busy, 1);
    reset_seq = 1'b1;
    tick();
    reset_seq = 1'b0;
    check("rstmid_step", pstep, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_rd", rd_val, 0);
    check("rstmid_err_tmo", e_tmo, 0);
    for (int i = 0; i < NCLK; i++) ref_phase[i] = 0;
    check_all_phases("rstmid_phase");
    n = 0;
    while (!pdone_m && n < 60) begin
      tick();
      n++;
    end
    repeat (4) tick();
    do_shift(2, 1'b1, 3, 4);
    read_phase(2, v);
    check("post_rst_phase2", v, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
